// File: rtl/vec_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : vec_hazard_scoreboard
// Purpose  : Issue-side hazard scoreboard for the vector coprocessor. Tracks
//            pending VRF writes (one bit per register) and pending VRF reads
//            (a small counter per register). Blocks dispatch on RAW, WAW and
//            WAR hazards, on read-counter saturation and when the number of
//            in-flight instructions has reached MAX_OUTSTANDING.
//
// Ports    : clk_i, rst_ni          clock, synchronous active-low reset
//            chk_*_i                candidate instruction fields
//            chk_ok_o               candidate may dispatch (combinational)
//            disp_valid_i           candidate dispatched this cycle
//            cmpl_valid_i, cmpl_*_i completing instruction and its fields
//            flush_i                drop all tracking state (err kept)
//            wbusy_o                per-register write-pending bits
//            outstanding_o          in-flight instruction count
//            err_o                  sticky protocol error (reset clears)
//
// Options  : VEC_SB_BYPASS_EN - when defined, chk_ok_o evaluates the state as
//            if this cycle's completion had already been applied.
//
// Revision : 1.0 - initial release
// ============================================================================
module vec_hazard_scoreboard #(
    parameter int NUM_VREGS       = 16,
    parameter int RCNT_W          = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [$clog2(NUM_VREGS)-1:0]         chk_vs1_i,
    input  logic                                 chk_re1_i,
    input  logic [$clog2(NUM_VREGS)-1:0]         chk_vs2_i,
    input  logic                                 chk_re2_i,
    input  logic [$clog2(NUM_VREGS)-1:0]         chk_vd_i,
    input  logic                                 chk_we_i,
    output logic                                 chk_ok_o,
    input  logic                                 disp_valid_i,
    input  logic                                 cmpl_valid_i,
    input  logic [$clog2(NUM_VREGS)-1:0]         cmpl_vs1_i,
    input  logic [$clog2(NUM_VREGS)-1:0]         cmpl_vs2_i,
    input  logic [$clog2(NUM_VREGS)-1:0]         cmpl_vd_i,
    input  logic                                 cmpl_re1_i,
    input  logic                                 cmpl_re2_i,
    input  logic                                 cmpl_we_i,
    input  logic                                 flush_i,
    output logic [NUM_VREGS-1:0]                 wbusy_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int                 c_VREG_W   = $clog2(NUM_VREGS);
    localparam int                 c_OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [RCNT_W-1:0]  c_RCNT_MAX = {RCNT_W{1'b1}};
    localparam logic [RCNT_W-1:0]  c_RCNT_ONE = RCNT_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_MAX  = c_OUT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_VREGS-1:0] r_wpend;
    logic [RCNT_W-1:0]    r_rcnt [NUM_VREGS];
    logic [c_OUT_W-1:0]   r_outstanding;
    logic                 r_err;

    // One-hot register select, zero when the field is not enabled. OR-ing two
    // of these gives the read set, so vs1==vs2 collapses to a single bit.
    function automatic logic [NUM_VREGS-1:0] f_sel(
        input logic [c_VREG_W-1:0] idx,
        input logic                en
    );
        logic [NUM_VREGS-1:0] v;
        v = '0;
        if (en) v[idx] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Register sets of the candidate and of the completing instruction
    // ------------------------------------------------------------------------
    logic [NUM_VREGS-1:0] w_disp_rd;
    logic [NUM_VREGS-1:0] w_disp_wr;
    logic [NUM_VREGS-1:0] w_cmpl_rd;
    logic [NUM_VREGS-1:0] w_cmpl_wr;

    assign w_disp_rd = f_sel(chk_vs1_i, chk_re1_i) | f_sel(chk_vs2_i, chk_re2_i);
    assign w_disp_wr = f_sel(chk_vd_i, chk_we_i);
    assign w_cmpl_rd = f_sel(cmpl_vs1_i, cmpl_valid_i & cmpl_re1_i)
                     | f_sel(cmpl_vs2_i, cmpl_valid_i & cmpl_re2_i);
    assign w_cmpl_wr = f_sel(cmpl_vd_i, cmpl_valid_i & cmpl_we_i);

    // Per-register counter status flags
    logic [NUM_VREGS-1:0] w_rcnt_nz;
    logic [NUM_VREGS-1:0] w_rcnt_one;
    logic [NUM_VREGS-1:0] w_rcnt_sat;

    for (genvar gi = 0; gi < NUM_VREGS; gi++) begin : g_vreg
        assign w_rcnt_nz[gi]  = (r_rcnt[gi] != '0);
        assign w_rcnt_one[gi] = (r_rcnt[gi] == c_RCNT_ONE);
        assign w_rcnt_sat[gi] = (r_rcnt[gi] == c_RCNT_MAX);
    end

    // ------------------------------------------------------------------------
    // Completion: only fields that are actually pending are released; any
    // field that is not pending is an underflow and stays as it is.
    // ------------------------------------------------------------------------
    logic [NUM_VREGS-1:0] w_wr_clr;
    logic [NUM_VREGS-1:0] w_cmpl_dec;
    logic                 w_out_dec;
    logic                 w_cmpl_uflow;

    assign w_wr_clr     = w_cmpl_wr & r_wpend;
    assign w_cmpl_dec   = w_cmpl_rd & w_rcnt_nz;
    assign w_out_dec    = cmpl_valid_i && (r_outstanding != '0);
    assign w_cmpl_uflow = (|(w_cmpl_wr & ~r_wpend))
                        | (|(w_cmpl_rd & ~w_rcnt_nz))
                        | (cmpl_valid_i && (r_outstanding == '0));

    // ------------------------------------------------------------------------
    // State as seen by the hazard check
    // ------------------------------------------------------------------------
    logic [NUM_VREGS-1:0] w_view_wpend;
    logic [NUM_VREGS-1:0] w_view_rnz;
    logic [NUM_VREGS-1:0] w_view_rsat;
    logic [c_OUT_W-1:0]   w_view_out;

`ifdef VEC_SB_BYPASS_EN
    // Look through this cycle's completion: a counter at one that is being
    // released reads as zero, a saturated counter being released has room.
    assign w_view_wpend = r_wpend & ~w_wr_clr;
    assign w_view_rnz   = w_rcnt_nz & ~(w_cmpl_dec & w_rcnt_one);
    assign w_view_rsat  = w_rcnt_sat & ~w_cmpl_dec;
    assign w_view_out   = r_outstanding - c_OUT_W'(w_out_dec);
`else
    assign w_view_wpend = r_wpend;
    assign w_view_rnz   = w_rcnt_nz;
    assign w_view_rsat  = w_rcnt_sat;
    assign w_view_out   = r_outstanding;
`endif

    logic w_no_raw;
    logic w_no_waw;
    logic w_no_war;
    logic w_no_sat;
    logic w_has_room;

    assign w_no_raw   = ~|(w_disp_rd & w_view_wpend);
    assign w_no_waw   = ~|(w_disp_wr & w_view_wpend);
    assign w_no_war   = ~|(w_disp_wr & w_view_rnz);
    assign w_no_sat   = ~|(w_disp_rd & w_view_rsat);
    assign w_has_room = (w_view_out < c_OUT_MAX);

    assign chk_ok_o = w_no_raw & w_no_waw & w_no_war & w_no_sat & w_has_room;

    // ------------------------------------------------------------------------
    // Dispatch
    // ------------------------------------------------------------------------
    logic                 w_disp_fire;
    logic                 w_disp_bad;
    logic [NUM_VREGS-1:0] w_wr_set;
    logic [NUM_VREGS-1:0] w_rcnt_inc;

    assign w_disp_fire = disp_valid_i & chk_ok_o;
    assign w_disp_bad  = disp_valid_i & ~chk_ok_o;
    assign w_wr_set    = w_disp_fire ? w_disp_wr : '0;
    assign w_rcnt_inc  = w_disp_fire ? w_disp_rd : '0;

    // ------------------------------------------------------------------------
    // State update. Set wins over clear on wpend so a same-cycle complete and
    // re-dispatch to one vd leaves it pending. Increment and decrement of one
    // counter cancel. Neither can overflow: dispatch is gated on saturation
    // and capacity, and decrements are gated on non-zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wpend       <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            for (int i = 0; i < NUM_VREGS; i++) begin
                r_rcnt[i] <= '0;
            end
        end else if (flush_i) begin
            r_wpend       <= '0;
            r_outstanding <= '0;
            for (int i = 0; i < NUM_VREGS; i++) begin
                r_rcnt[i] <= '0;
            end
        end else begin
            r_wpend       <= (r_wpend & ~w_wr_clr) | w_wr_set;
            r_outstanding <= r_outstanding + c_OUT_W'(w_disp_fire)
                                           - c_OUT_W'(w_out_dec);
            r_err         <= r_err | w_disp_bad | w_cmpl_uflow;
            for (int i = 0; i < NUM_VREGS; i++) begin
                r_rcnt[i] <= r_rcnt[i] + RCNT_W'(w_rcnt_inc[i])
                                       - RCNT_W'(w_cmpl_dec[i]);
            end
        end
    end

    assign wbusy_o       = r_wpend;
    assign outstanding_o = r_outstanding;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_hazard_scoreboard
// Purpose  : Self-checking bench for vec_hazard_scoreboard. Directed scenarios
//            followed by randomized traffic, compared every cycle against a
//            behavioural model kept as plain integer arrays and a queue of
//            in-flight instructions. Honours VEC_SB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_hazard_scoreboard;

    localparam int c_NV   = 16;
    localparam int c_RMAX = 3;   // all-ones of a 2-bit read counter
    localparam int c_MAXO = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] chk_vs1, chk_vs2, chk_vd;
    logic       chk_re1, chk_re2, chk_we;
    logic       chk_ok;
    logic       disp_valid;
    logic       cmpl_valid;
    logic [3:0] cmpl_vs1, cmpl_vs2, cmpl_vd;
    logic       cmpl_re1, cmpl_re2, cmpl_we;
    logic       flush;
    logic [15:0] wbusy;
    logic [2:0] outstanding;
    logic       err;

    vec_hazard_scoreboard #(
        .NUM_VREGS      (16),
        .RCNT_W         (2),
        .MAX_OUTSTANDING(4)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .chk_vs1_i    (chk_vs1),
        .chk_re1_i    (chk_re1),
        .chk_vs2_i    (chk_vs2),
        .chk_re2_i    (chk_re2),
        .chk_vd_i     (chk_vd),
        .chk_we_i     (chk_we),
        .chk_ok_o     (chk_ok),
        .disp_valid_i (disp_valid),
        .cmpl_valid_i (cmpl_valid),
        .cmpl_vs1_i   (cmpl_vs1),
        .cmpl_vs2_i   (cmpl_vs2),
        .cmpl_vd_i    (cmpl_vd),
        .cmpl_re1_i   (cmpl_re1),
        .cmpl_re2_i   (cmpl_re2),
        .cmpl_we_i    (cmpl_we),
        .flush_i      (flush),
        .wbusy_o      (wbusy),
        .outstanding_o(outstanding),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [3:0] vs1, vs2, vd;
        bit         re1, re2, we;
    } instr_t;

    int     m_wpend [c_NV];
    int     m_rcnt  [c_NV];
    int     m_out;
    bit     m_err;
    instr_t m_q[$];

    // Distinct registers read by an instruction
    function automatic void read_set(input logic [3:0] a, input bit ea,
                                     input logic [3:0] b, input bit eb,
                                     output int s[$]);
        s = {};
        if (ea) s.push_back(int'(a));
        if (eb && !(ea && a == b)) s.push_back(int'(b));
    endfunction

    function automatic bit model_ok();
        int wp[c_NV];
        int rc[c_NV];
        int oc;
        int s[$];
        bit ok;
        for (int i = 0; i < c_NV; i++) begin
            wp[i] = m_wpend[i];
            rc[i] = m_rcnt[i];
        end
        oc = m_out;
`ifdef VEC_SB_BYPASS_EN
        if (cmpl_valid) begin
            if (cmpl_we) wp[cmpl_vd] = 0;
            read_set(cmpl_vs1, cmpl_re1, cmpl_vs2, cmpl_re2, s);
            foreach (s[k]) if (rc[s[k]] > 0) rc[s[k]]--;
            if (oc > 0) oc--;
        end
`endif
        ok = 1'b1;
        read_set(chk_vs1, chk_re1, chk_vs2, chk_re2, s);
        foreach (s[k]) begin
            if (wp[s[k]] != 0)      ok = 1'b0;
            if (rc[s[k]] == c_RMAX) ok = 1'b0;
        end
        if (chk_we && wp[chk_vd] != 0) ok = 1'b0;
        if (chk_we && rc[chk_vd] != 0) ok = 1'b0;
        if (oc >= c_MAXO)              ok = 1'b0;
        return ok;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < c_NV; i++) begin
            m_wpend[i] = 0;
            m_rcnt[i]  = 0;
        end
        m_out = 0;
        m_q   = {};
    endfunction

    // One clock edge: all decisions are made from the pre-edge state.
    function automatic void model_step(input bit ok);
        int     s[$];
        int     old_wp[c_NV];
        int     old_rc[c_NV];
        int     old_out;
        instr_t ins;
        if (!rst_n) begin
            model_clear();
            m_err = 1'b0;
            return;
        end
        if (flush) begin
            model_clear();
            return;
        end
        for (int i = 0; i < c_NV; i++) begin
            old_wp[i] = m_wpend[i];
            old_rc[i] = m_rcnt[i];
        end
        old_out = m_out;
        if (cmpl_valid) begin
            if (cmpl_we) begin
                if (old_wp[cmpl_vd] == 0) m_err = 1'b1;
                else                      m_wpend[cmpl_vd] = 0;
            end
            read_set(cmpl_vs1, cmpl_re1, cmpl_vs2, cmpl_re2, s);
            foreach (s[k]) begin
                if (old_rc[s[k]] == 0) m_err = 1'b1;
                else                   m_rcnt[s[k]]--;
            end
            if (old_out == 0) m_err = 1'b1;
            else              m_out--;
        end
        if (disp_valid && ok) begin
            if (chk_we) m_wpend[chk_vd] = 1;
            read_set(chk_vs1, chk_re1, chk_vs2, chk_re2, s);
            foreach (s[k]) m_rcnt[s[k]]++;
            m_out++;
            ins.vs1 = chk_vs1; ins.re1 = chk_re1;
            ins.vs2 = chk_vs2; ins.re2 = chk_re2;
            ins.vd  = chk_vd;  ins.we  = chk_we;
            m_q.push_back(ins);
        end else if (disp_valid) begin
            m_err = 1'b1;
        end
    endfunction

    function automatic logic [15:0] model_wbusy();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < c_NV; i++) v[i] = (m_wpend[i] != 0);
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (always entered and left just after a falling edge)
    // ------------------------------------------------------------------------
    task automatic idle();
        rst_n = 1'b1; flush = 1'b0; disp_valid = 1'b0; cmpl_valid = 1'b0;
        chk_vs1 = '0; chk_vs2 = '0; chk_vd = '0;
        chk_re1 = 1'b0; chk_re2 = 1'b0; chk_we = 1'b0;
        cmpl_vs1 = '0; cmpl_vs2 = '0; cmpl_vd = '0;
        cmpl_re1 = 1'b0; cmpl_re2 = 1'b0; cmpl_we = 1'b0;
    endtask

    task automatic set_chk(input logic [3:0] vs1, input bit re1, input logic [3:0] vs2,
                           input bit re2, input logic [3:0] vd, input bit we);
        chk_vs1 = vs1; chk_re1 = re1; chk_vs2 = vs2; chk_re2 = re2; chk_vd = vd; chk_we = we;
    endtask

    task automatic set_cmpl(input logic [3:0] vs1, input bit re1, input logic [3:0] vs2,
                            input bit re2, input logic [3:0] vd, input bit we);
        cmpl_valid = 1'b1;
        cmpl_vs1 = vs1; cmpl_re1 = re1; cmpl_vs2 = vs2; cmpl_re2 = re2; cmpl_vd = vd; cmpl_we = we;
    endtask

    // Check chk_ok against the model, clock once, check registered outputs.
    task automatic tick();
        bit exp_ok;
        #1;
        exp_ok = model_ok();
        check_eq("chk_ok", {31'b0, chk_ok}, {31'b0, exp_ok});
        @(posedge clk);
        model_step(exp_ok);
        @(negedge clk);
        check_eq("wbusy", {16'b0, wbusy}, {16'b0, model_wbusy()});
        check_eq("outstanding", {29'b0, outstanding}, m_out);
        check_eq("err", {31'b0, err}, {31'b0, m_err});
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
    endtask

    task automatic disp_wr(input logic [3:0] vd);
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, vd, 1'b1);
        disp_valid = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        bit      exp_ok;
        int      idx;
        instr_t  ins;

        model_clear();
        m_err = 1'b0;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        check_eq("rst_wbusy", {16'b0, wbusy}, 32'd0);
        check_eq("rst_out", {29'b0, outstanding}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_ok", {31'b0, chk_ok}, 32'd1);

        // RAW
        disp_wr(4'd3);
        set_chk(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1 check_eq("raw_block", {31'b0, chk_ok}, 32'd0);
        tick();
        set_chk(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        set_cmpl(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1);
`ifdef VEC_SB_BYPASS_EN
        #1 check_eq("raw_cmpl_cycle", {31'b0, chk_ok}, 32'd1);
`else
        #1 check_eq("raw_cmpl_cycle", {31'b0, chk_ok}, 32'd0);
`endif
        tick();
        check_eq("raw_wbusy3", {31'b0, wbusy[3]}, 32'd0);
        set_chk(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        #1 check_eq("raw_free", {31'b0, chk_ok}, 32'd1);
        tick();

        // WAR with a single source used twice
        set_chk(4'd5, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0);
        disp_valid = 1'b1;
        tick();
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
        #1 check_eq("war_block", {31'b0, chk_ok}, 32'd0);
        tick();
        set_cmpl(4'd5, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0);
        tick();
        check_eq("war_err", {31'b0, err}, 32'd0);
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
        #1 check_eq("war_free", {31'b0, chk_ok}, 32'd1);
        tick();

        // Capacity
        for (int v = 0; v < 4; v++) disp_wr(4'(v));
        check_eq("cap_full", {29'b0, outstanding}, 32'd4);
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1);
        #1 check_eq("cap_block", {31'b0, chk_ok}, 32'd0);
        tick();
        set_cmpl(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        tick();
        check_eq("cap_out3", {29'b0, outstanding}, 32'd3);
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1);
        #1 check_eq("cap_free", {31'b0, chk_ok}, 32'd1);
        tick();
        do_reset();

        // Same-cycle dispatch and completion on vd=7
        disp_wr(4'd7);
        set_cmpl(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1);
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1);
        disp_valid = 1'b1;
        tick();
`ifdef VEC_SB_BYPASS_EN
        check_eq("sim_wbusy7", {31'b0, wbusy[7]}, 32'd1);
        check_eq("sim_out", {29'b0, outstanding}, 32'd1);
        check_eq("sim_err", {31'b0, err}, 32'd0);
`else
        check_eq("sim_wbusy7", {31'b0, wbusy[7]}, 32'd0);
        check_eq("sim_out", {29'b0, outstanding}, 32'd0);
        check_eq("sim_err", {31'b0, err}, 32'd1);
`endif
        do_reset();

        // Errors
        set_cmpl(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1);
        tick();
        check_eq("uf_err", {31'b0, err}, 32'd1);
        check_eq("uf_wbusy", {16'b0, wbusy}, 32'd0);
        check_eq("uf_out", {29'b0, outstanding}, 32'd0);
        disp_wr(4'd2);
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1);
        #1 check_eq("ill_block", {31'b0, chk_ok}, 32'd0);
        disp_valid = 1'b1;
        tick();
        check_eq("ill_out", {29'b0, outstanding}, 32'd1);
        for (int k = 0; k < 3; k++) tick();
        check_eq("err_sticky", {31'b0, err}, 32'd1);
        do_reset();
        check_eq("err_rst", {31'b0, err}, 32'd0);

        // Flush keeps err, reset clears everything
        set_cmpl(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        disp_wr(4'd1);
        disp_wr(4'd2);
        disp_wr(4'd3);
        check_eq("fl_out3", {29'b0, outstanding}, 32'd3);
        flush = 1'b1;
        set_cmpl(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1);
        tick();
        check_eq("fl_out", {29'b0, outstanding}, 32'd0);
        check_eq("fl_wbusy", {16'b0, wbusy}, 32'd0);
        check_eq("fl_err", {31'b0, err}, 32'd1);
        disp_wr(4'd4);
        disp_wr(4'd5);
        rst_n = 1'b0;
        set_chk(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1);
        disp_valid = 1'b1;
        tick();
        check_eq("mr_wbusy", {16'b0, wbusy}, 32'd0);
        check_eq("mr_out", {29'b0, outstanding}, 32'd0);
        check_eq("mr_err", {31'b0, err}, 32'd0);
        set_chk(4'd5, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1);
        #1 check_eq("mr_ok", {31'b0, chk_ok}, 32'd1);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idx = int'($urandom_range(0, 99));
            if (idx < 1)      rst_n = 1'b0;
            else if (idx < 3) flush = 1'b1;
            if ($urandom_range(0, 99) < 40 && m_q.size() > 0) begin
                idx = int'($urandom_range(0, m_q.size() - 1));
                ins = m_q[idx];
                m_q.delete(idx);
                set_cmpl(ins.vs1, ins.re1, ins.vs2, ins.re2, ins.vd, ins.we);
            end else if ($urandom_range(0, 99) < 3) begin
                set_cmpl(4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)),
                         1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom));
            end
            set_chk(4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)),
                    1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom));
            exp_ok = model_ok();
            disp_valid = exp_ok ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_hazard_scoreboard.md
Name: vec_hazard_scoreboard

Overview:
- Issue-side hazard scoreboard for the vector coprocessor.
- Sits between the X-IF issue decoder and the VLSU / vector execution unit dispatch.
- Tracks pending VRF writes and reads per vector register. Blocks dispatch on RAW, WAW and WAR hazards, and caps the number of outstanding vector instructions.
- Lets loads (VLSU) and arithmetic ops (exec unit), which have different latencies, be in flight together without corrupting the 16-entry VRF.

Parameters:
- NUM_VREGS, 16, number of vector registers tracked.
- RCNT_W, 2, width of each per-register pending-read counter.
- MAX_OUTSTANDING, 4, maximum number of dispatched, uncompleted instructions.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; one clock, synchronous, active-low
- chk_vs1_i  input  $clog2(NUM_VREGS)  candidate source 1
- chk_re1_i  input  1  candidate reads vs1
- chk_vs2_i  input  $clog2(NUM_VREGS)  candidate source 2
- chk_re2_i  input  1  candidate reads vs2
- chk_vd_i  input  $clog2(NUM_VREGS)  candidate destination
- chk_we_i  input  1  candidate writes vd
- chk_ok_o  output  1  candidate may dispatch this cycle (combinational)
- disp_valid_i  input  1  candidate dispatched this cycle (same fields as chk_*)
- cmpl_valid_i  input  1  an instruction completed
- cmpl_vs1_i, cmpl_vs2_i, cmpl_vd_i  input  $clog2(NUM_VREGS) each  fields of the completing instruction
- cmpl_re1_i, cmpl_re2_i, cmpl_we_i  input  1 each  flags of the completing instruction
- flush_i  input  1  discard all tracking state
- wbusy_o  output  NUM_VREGS  per-register write-pending bits
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  in-flight instruction count
- err_o  output  1  sticky protocol error

Behaviour:
- State:
  - wpend[NUM_VREGS] bits.
  - rcnt[NUM_VREGS][RCNT_W] counters.
  - outstanding counter.
  - err flag.
- Reset (rst_ni low at a clk_i edge): all state cleared. Outputs wbusy_o=0, outstanding_o=0, err_o=0. chk_ok_o=1, since it follows from the cleared state.
- Effective read set: vs1 if re1, plus vs2 if re2. When vs1==vs2 with both enabled, the register is counted once. The same rule applies on dispatch and on completion.
- chk_ok_o=1 only when all of the following hold:
  - No RAW: no read in the read set has wpend set.
  - No WAW: if we, wpend[vd] is clear.
  - No WAR: if we, rcnt[vd]==0.
  - No read-counter saturation: no register in the read set has rcnt at all-ones.
  - Capacity: outstanding < MAX_OUTSTANDING.
- Dispatch (disp_valid_i && chk_ok_o), updated at the next edge:
  - set wpend[vd] if we;
  - increment rcnt of each register in the read set;
  - outstanding+1.
- Illegal dispatch (disp_valid_i && !chk_ok_o): state is unchanged, err_o set.
- Completion (cmpl_valid_i), updated at the next edge:
  - clear wpend[vd] if we;
  - decrement rcnt of each register in the read set;
  - outstanding-1.
- Completion underflow: a completion that would clear an already-clear wpend, decrement a zero rcnt, or complete with outstanding==0 sets err_o. The offending field is left unchanged (no wrap); the legal fields still update.
- Same-cycle dispatch and completion: both apply.
  - Same rcnt: net unchanged.
  - Same wpend (completion clears, dispatch sets): ends set.
  - outstanding: unchanged.
- flush_i: highest priority after reset. Next cycle all wpend, rcnt and outstanding are 0. err_o is preserved. Dispatch and completion in the flush cycle are ignored.
- err_o clears only on reset.
- Latency:
  - chk_ok_o is combinational from chk_* and the registered state.
  - wbusy_o and outstanding_o reflect updates one cycle after the event.

Optional Feature:
- Macro: VEC_SB_BYPASS_EN.
- Defined: chk_ok_o evaluates the state as if the same-cycle completion had already been applied. A completing write to vd, a completing read release, or the freed outstanding slot allows dispatch in that same cycle.
  - Dispatch accepted this way is legal and does not flag err_o.
  - The underflow rules are unchanged.
- Undefined: chk_ok_o uses registered state only, so a freed hazard is visible one cycle after completion.

Test Plan:
1. RAW:
   - Dispatch vd=3 we=1.
   - Next cycle, check re1=1 vs1=3 -> chk_ok_o=0.
   - cmpl_vd=3 we=1 -> wbusy_o[3]=0 next cycle, then chk_ok_o=1. With VEC_SB_BYPASS_EN, chk_ok_o=1 already in the completion cycle.
2. WAR and same-source:
   - Dispatch re1=re2=1 vs1=vs2=5.
   - Check we=1 vd=5 -> chk_ok_o=0.
   - Complete the same fields -> rcnt[5] returns to 0 (not wrapped), err_o=0, then chk_ok_o=1.
3. Capacity:
   - Dispatch 4 independent writes vd=0..3 -> outstanding_o=4, and a 5th candidate vd=8 -> chk_ok_o=0.
   - One completion -> outstanding_o=3, chk_ok_o=1.
4. Simultaneous events:
   - Dispatch vd=7 while completing vd=7 in the same cycle (with bypass) -> wbusy_o[7]=1, outstanding_o unchanged.
5. Errors:
   - Completion vd=9 we=1 with nothing pending -> err_o=1, wbusy_o=0, outstanding_o=0.
   - disp_valid_i while chk_ok_o=0 -> err_o stays 1 until rst_ni low.
6. Flush and reset:
   - Three in flight, then flush_i -> outstanding_o=0, wbusy_o=0 next cycle, err_o kept.
   - rst_ni low mid-operation -> all outputs zero at the next edge, chk_ok_o=1.
